decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Parametrised ID/EX stage for the five-stage RISC-V core. It decodes the D-stage instruction, reads a write-first register file, and detects load-use hazards. It registers controls, operands, immediate and register indices into the E stage, inserting bubbles on hazards and flushes. Successor of the fixed 32-bit decode stage: it adds XLEN/regfile parametrisation, a valid bit, flush, stall generation, and rs1/rs2 export for the forwarding unit.

## Interface
- XLEN, 32, datapath width (32 or 64)
- REG_AW, 5, register index width; register count = 2**REG_AW
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ValidD  in  1  D-stage instruction valid
- InstrD  in  32  instruction word
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of D instruction
- RegWriteW  in  1  write-back enable
- RDW  in  REG_AW  write-back destination
- ResultW  in  XLEN  write-back data
- FlushE  in  1  branch taken in E; squash instruction entering E
- StallD  out  1  load-use hazard; F and D must hold
- ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  E-stage controls
- ALUControlE  out  3  ALU operation
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  E-stage data
- Rs1E, Rs2E, RD_E  out  REG_AW  source and destination indices for forwarding

## Operation
- Supported opcodes:
  - lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I
  - sw 0100011: MemWrite=1, ALUSrc=1, ImmSrc=S
  - R-type 0110011: RegWrite=1
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, ImmSrc=I
  - beq 1100011: Branch=1, ImmSrc=B
  - All other opcodes decode as all-zero controls (a nop).
- ALUControl:
  - add 000, sub 001, and 010, or 011, slt 101.
  - sub is selected when funct3=000, op[5]=1 and funct7[5]=1, or when the opcode is beq.
- Immediates are sign-extended to XLEN from InstrD[31].
- Register file: 2**REG_AW×XLEN. Register x0 reads 0 and ignores writes.
- Load-use hazard:
  - StallD = ValidD & ValidE & ResultSrcE & (RD_E≠0) & (RD_E==rs1D | RD_E==rs2D). It is combinational.
  - Compare rs2D only for opcodes that read rs2 (R-type, sw, beq).
- E-register update, in priority order:
  - rst: clear all.
  - FlushE: bubble.
  - StallD: bubble.
  - ValidD=0: bubble.
  - Otherwise: load the decoded fields.
- Bubble: ValidE, RegWriteE, MemWriteE, BranchE, ResultSrcE = 0. All other E fields = 0, for deterministic waveforms.
- FlushE together with StallD produces a bubble. StallD still asserts, because it is computed from the current ValidE.

## Timing
- Latency D→E is 1 cycle.
- StallD has combinational decode-to-output delay in the same cycle, with no registered delay.
- Register-file write commits at the rising edge when RegWriteW & RDW≠0.
- A read of the same index in the same cycle returns ResultW (behaviour controlled by the macro below).
- Reset:
  - Every E output and all register-file entries are 0.
  - StallD is 0, because ValidE is 0.
  - Reset asserted mid-operation discards in-flight E contents immediately. It does not wait for a clock edge.
- Stall lasts exactly one cycle per load-use hazard: the bubble clears ValidE, which clears the hazard.

## Configuration
- DECODE_WB_BYPASS_EN defined: write-first read. When RegWriteW & RDW==rsX & RDW≠0, RD1/RD2 return ResultW in the same cycle.
- Undefined: reads return the stored value only. A W→D dependency in the same cycle sees the old value, and software must separate such instructions by one slot.

## Structure
- Package decode_pkg holds:
  - Opcode localparams.
  - ALU op codes.
  - ImmSrc enum: I, S, B.
  - A control struct: RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc, ALUControl.
  - Function decode_ctrl(op, funct3, funct7).
- One sub-module, regfile_wf, parametrised by XLEN and REG_AW: two read ports, one write port, async-reset array, optional bypass.

## Test plan
- Reset: rst pulse mid-run with E loaded → all E outputs 0 and StallD=0 immediately. Subsequent reads of x5 return 0.
- add x3,x1,x2 (0x002081B3) with x1=7, x2=9 preloaded → next cycle RD1_E=7, RD2_E=9, RD_E=3, ALUControlE=000, RegWriteE=1, ValidE=1.
- lw x4,8(x1) followed by add x5,x4,x2:
  - StallD=1 for one cycle.
  - E receives a bubble (ValidE=0, RegWriteE=0).
  - The add enters E the following cycle.
- FlushE=1 with beq in D → E becomes a bubble, BranchE=0.
- Same-cycle write of x6=0xDEAD with read of x6:
  - With DECODE_WB_BYPASS_EN: RD1_E=0xDEAD.
  - Without it: old value.
- Write to x0 with ResultW=0x1234 → later read of x0 returns 0.
- XLEN=64: sw with immediate −4 → Imm_Ext_E=0xFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Decode definitions shared by the ID/EX stage: opcodes, ALU codes,
// immediate formats, the control bundle and the main decoder.
package decode_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_src_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    imm_src_e   imm_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // Only R-type, stores and branches consume rs2; others carry immediate bits there.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Main decoder; unknown opcodes fall out as an all-zero (nop) bundle.
  function automatic ctrl_t decode_ctrl(input logic [6:0] op,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    ctrl_t c;
    c = '{default: '0, imm_src: IMM_I};
    case (op)
      OP_LW:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = 1'b1; end
      OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_S; end
      OP_RTYPE: c.reg_write = 1'b1;
      OP_IALU:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_BEQ:   begin c.branch = 1'b1; c.imm_src = IMM_B; c.alu_control = ALU_SUB; end
      default:  ;
    endcase
    if (op == OP_RTYPE || op == OP_IALU) begin
      case (funct3)
        3'b000:  c.alu_control = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b010:  c.alu_control = ALU_SLT;
        3'b110:  c.alu_control = ALU_OR;
        3'b111:  c.alu_control = ALU_AND;
        default: c.alu_control = ALU_ADD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// D-side inputs, write-back port, flush, and the E-stage outputs of the
// decode stage. master = surrounding pipeline, slave = decode stage.
interface decode_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              ValidD;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;

  logic              StallD;
  logic              ValidE;
  logic              RegWriteE;
  logic              ALUSrcE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   Imm_Ext_E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RD_E;

  modport master (
    output ValidD, InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, Rs1E, Rs2E, RD_E
  );

  modport slave (
    input  ValidD, InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, Rs1E, Rs2E, RD_E
  );
endinterface

// File: rtl/decode_stage_pipe_regfile.sv
// Register file: two async read ports, one write port, x0 hard-wired to 0.
// Define DECODE_WB_BYPASS_EN for write-first reads (same-cycle W->D forwarding).
module regfile_wf #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [XLEN-1:0]   o_rd1,
  output logic [XLEN-1:0]   o_rd2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [XLEN-1:0]   i_wd
);
  localparam int NREG = 2 ** REG_AW;

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr_en;
  logic [XLEN-1:0] w_rd1_raw;
  logic [XLEN-1:0] w_rd2_raw;

  assign w_wr_en = i_we && (i_wa != '0);

  // Commit write-back data; the whole array clears on reset.
  // NOTE: the array is reset because the core relies on every register reading 0 after reset; sequential state uses <= so all entries update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign w_rd1_raw = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign w_rd2_raw = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

`ifdef DECODE_WB_BYPASS_EN
  assign o_rd1 = (w_wr_en && (i_wa == i_ra1)) ? i_wd : w_rd1_raw;
  assign o_rd2 = (w_wr_en && (i_wa == i_ra2)) ? i_wd : w_rd2_raw;
`else
  assign o_rd1 = w_rd1_raw;
  assign o_rd2 = w_rd2_raw;
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// ID/EX stage: decodes D, reads the register file, detects load-use
// hazards and registers everything into E, bubbling on flush/stall/invalid.
// Optional macro DECODE_WB_BYPASS_EN selects write-first register reads.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic                clk,
  input logic                rst,
  decode_stage_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic              result_src;
    logic              branch;
    logic [2:0]        alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } e_reg_t;

  logic [31:0]       w_instr;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;
  logic              w_stall;
  logic              w_bubble;
  e_reg_t            r_e;

  assign w_instr = bus.InstrD;
  assign w_rs1   = REG_AW'(w_instr[19:15]);
  assign w_rs2   = REG_AW'(w_instr[24:20]);
  assign w_rd    = REG_AW'(w_instr[11:7]);
  assign w_ctrl  = decode_ctrl(w_instr[6:0], w_instr[14:12], w_instr[31:25]);

  // Immediate extraction, sign-extended to XLEN from bit 31.
  // NOTE: the default assignment up front keeps this block free of latches for any imm_src value.
  always_comb begin
    w_imm = '0;
    case (w_ctrl.imm_src)
      IMM_I:   w_imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
      IMM_S:   w_imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      IMM_B:   w_imm = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7],
                        w_instr[30:25], w_instr[11:8], 1'b0};
      default: w_imm = '0;
    endcase
  end

  regfile_wf #(.XLEN(XLEN), .REG_AW(REG_AW)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (bus.RegWriteW),
    .i_wa  (bus.RDW),
    .i_wd  (bus.ResultW)
  );

  // A load in E whose destination a D source needs: hold F/D for one slot.
  assign w_stall = bus.ValidD && r_e.valid && r_e.result_src && (r_e.rd != '0) &&
                   ((r_e.rd == w_rs1) || (uses_rs2(w_instr[6:0]) && (r_e.rd == w_rs2)));
  assign w_bubble = bus.FlushE || w_stall || !bus.ValidD;

  // E pipeline register: clear on reset or bubble, else capture decoded fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e <= '0;
    end else if (w_bubble) begin
      r_e <= '0;
    end else begin
      r_e.valid       <= 1'b1;
      r_e.reg_write   <= w_ctrl.reg_write;
      r_e.alu_src     <= w_ctrl.alu_src;
      r_e.mem_write   <= w_ctrl.mem_write;
      r_e.result_src  <= w_ctrl.result_src;
      r_e.branch      <= w_ctrl.branch;
      r_e.alu_control <= w_ctrl.alu_control;
      r_e.rd1         <= w_rd1;
      r_e.rd2         <= w_rd2;
      r_e.imm         <= w_imm;
      r_e.pc          <= bus.PCD;
      r_e.pc_plus4    <= bus.PCPlus4D;
      r_e.rs1         <= w_rs1;
      r_e.rs2         <= w_rs2;
      r_e.rd          <= w_rd;
    end
  end

  assign bus.StallD      = w_stall;
  assign bus.ValidE      = r_e.valid;
  assign bus.RegWriteE   = r_e.reg_write;
  assign bus.ALUSrcE     = r_e.alu_src;
  assign bus.MemWriteE   = r_e.mem_write;
  assign bus.ResultSrcE  = r_e.result_src;
  assign bus.BranchE     = r_e.branch;
  assign bus.ALUControlE = r_e.alu_control;
  assign bus.RD1_E       = r_e.rd1;
  assign bus.RD2_E       = r_e.rd2;
  assign bus.Imm_Ext_E   = r_e.imm;
  assign bus.PCE         = r_e.pc;
  assign bus.PCPlus4E    = r_e.pc_plus4;
  assign bus.Rs1E        = r_e.rs1;
  assign bus.Rs2E        = r_e.rs2;
  assign bus.RD_E        = r_e.rd;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a vector table for single-cycle
// decode plus hand sequences for stall, flush, bypass, x0, reset and XLEN=64.
`timescale 1ns/1ps
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus32 ();
  decode_stage_pipe_if #(.XLEN(64), .REG_AW(5)) bus64 ();

  decode_stage_pipe #(.XLEN(32), .REG_AW(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  decode_stage_pipe #(.XLEN(64), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

  typedef struct {
    logic        valid, reg_write, alu_src, mem_write, result_src, branch;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    bit          chk_imm;
  } exp_e_t;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic        exp_stall;
    exp_e_t      e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_e_t mk_e(input logic v, rw, as, mw, rs, br, input logic [2:0] alu,
                                  input logic [31:0] rd1, rd2, imm, input bit ci,
                                  input logic [4:0] rs1, rs2, rd);
    exp_e_t e;
    e.valid = v; e.reg_write = rw; e.alu_src = as; e.mem_write = mw;
    e.result_src = rs; e.branch = br; e.alu = alu;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.chk_imm = ci;
    e.pc = '0; e.pc4 = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    return e;
  endfunction

  function automatic exp_e_t bubble();
    return mk_e(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  task automatic check_e(input string tag, input exp_e_t e);
    check({tag, ".ValidE"},      64'(bus32.ValidE),      64'(e.valid));
    check({tag, ".RegWriteE"},   64'(bus32.RegWriteE),   64'(e.reg_write));
    check({tag, ".ALUSrcE"},     64'(bus32.ALUSrcE),     64'(e.alu_src));
    check({tag, ".MemWriteE"},   64'(bus32.MemWriteE),   64'(e.mem_write));
    check({tag, ".ResultSrcE"},  64'(bus32.ResultSrcE),  64'(e.result_src));
    check({tag, ".BranchE"},     64'(bus32.BranchE),     64'(e.branch));
    check({tag, ".ALUControlE"}, 64'(bus32.ALUControlE), 64'(e.alu));
    check({tag, ".RD1_E"},       64'(bus32.RD1_E),       64'(e.rd1));
    check({tag, ".RD2_E"},       64'(bus32.RD2_E),       64'(e.rd2));
    if (e.chk_imm) check({tag, ".Imm_Ext_E"}, 64'(bus32.Imm_Ext_E), 64'(e.imm));
    check({tag, ".PCE"},         64'(bus32.PCE),         64'(e.pc));
    check({tag, ".PCPlus4E"},    64'(bus32.PCPlus4E),    64'(e.pc4));
    check({tag, ".Rs1E"},        64'(bus32.Rs1E),        64'(e.rs1));
    check({tag, ".Rs2E"},        64'(bus32.Rs2E),        64'(e.rs2));
    check({tag, ".RD_E"},        64'(bus32.RD_E),        64'(e.rd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
    bus32.ValidD   = vld;
    bus32.InstrD   = instr;
    bus32.PCD      = pc;
    bus32.PCPlus4D = pc + 32'd4;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    bus32.RegWriteW = 1'b1;
    bus32.RDW       = rd;
    bus32.ResultW   = data;
    tick();
    bus32.RegWriteW = 1'b0;
  endtask

  localparam logic [31:0] I_LW_X4      = 32'h0080A203; // lw  x4,8(x1)
  localparam logic [31:0] I_ADD_5_4_2  = 32'h002202B3; // add x5,x4,x2
  localparam logic [31:0] I_ADD_5_2_4  = 32'h004102B3; // add x5,x2,x4
  localparam logic [31:0] I_BEQ_P16    = 32'h00208863; // beq x1,x2,+16
  localparam logic [31:0] I_ADD_7_6_0  = 32'h000303B3; // add x7,x6,x0
  localparam logic [31:0] I_ADD_7_0_0  = 32'h000003B3; // add x7,x0,x0
  localparam logic [31:0] I_ADD_7_5_0  = 32'h000283B3; // add x7,x5,x0
  localparam logic [31:0] I_SW_M4      = 32'hFE20AE23; // sw  x2,-4(x1)

  vec_t        vecs [15];
  exp_e_t      ex;
  logic [31:0] pc;
  logic [31:0] exp_bypass;

  initial begin
    // Registers: x1=7, x2=9, x5=0x55, x6=0x100, all others 0.
    vecs[0]  = '{1, 32'h002081B3, 0, mk_e(1,1,0,0,0,0,3'b000, 7, 9, 0, 0, 1, 2, 3)};          // add x3,x1,x2
    vecs[1]  = '{1, 32'h402081B3, 0, mk_e(1,1,0,0,0,0,3'b001, 7, 9, 0, 0, 1, 2, 3)};          // sub x3,x1,x2
    vecs[2]  = '{1, 32'h0020F3B3, 0, mk_e(1,1,0,0,0,0,3'b010, 7, 9, 0, 0, 1, 2, 7)};          // and x7,x1,x2
    vecs[3]  = '{1, 32'h0020E3B3, 0, mk_e(1,1,0,0,0,0,3'b011, 7, 9, 0, 0, 1, 2, 7)};          // or  x7,x1,x2
    vecs[4]  = '{1, 32'h0020A3B3, 0, mk_e(1,1,0,0,0,0,3'b101, 7, 9, 0, 0, 1, 2, 7)};          // slt x7,x1,x2
    vecs[5]  = '{1, 32'hFFB08413, 0, mk_e(1,1,1,0,0,0,3'b000, 7, 0, 32'hFFFFFFFB, 1, 1, 27, 8)}; // addi x8,x1,-5
    vecs[6]  = '{1, 32'h0020A423, 0, mk_e(1,0,1,1,0,0,3'b000, 7, 9, 8, 1, 1, 2, 8)};          // sw x2,8(x1)
    vecs[7]  = '{1, I_BEQ_P16,    0, mk_e(1,0,0,0,0,1,3'b001, 7, 9, 16, 1, 1, 2, 16)};        // beq +16
    vecs[8]  = '{1, 32'hFE208EE3, 0, mk_e(1,0,0,0,0,1,3'b001, 7, 9, 32'hFFFFFFFC, 1, 1, 2, 29)}; // beq -4
    vecs[9]  = '{1, 32'h000002B7, 0, mk_e(1,0,0,0,0,0,3'b000, 0, 0, 0, 0, 0, 0, 5)};          // lui: nop controls
    vecs[10] = '{0, 32'h002081B3, 0, bubble()};                                              // ValidD=0
    vecs[11] = '{1, I_LW_X4,      0, mk_e(1,1,1,0,1,0,3'b000, 7, 0, 8, 1, 1, 8, 4)};          // lw x4,8(x1)
    vecs[12] = '{1, 32'h00408493, 0, mk_e(1,1,1,0,0,0,3'b000, 7, 0, 4, 1, 1, 4, 9)};          // addi x9,x1,4: rs2 field not compared
    vecs[13] = '{1, 32'h0080A003, 0, mk_e(1,1,1,0,1,0,3'b000, 7, 0, 8, 1, 1, 8, 0)};          // lw x0,8(x1)
    vecs[14] = '{1, 32'h002001B3, 0, mk_e(1,1,0,0,0,0,3'b000, 0, 9, 0, 0, 0, 2, 3)};          // add x3,x0,x2: rd_E=0

    rst = 1'b1;
    drive(0, 32'h0, 32'h0);
    bus32.RegWriteW = 0; bus32.RDW = '0; bus32.ResultW = '0; bus32.FlushE = 0;
    bus64.ValidD = 0; bus64.InstrD = '0; bus64.PCD = '0; bus64.PCPlus4D = '0;
    bus64.RegWriteW = 0; bus64.RDW = '0; bus64.ResultW = '0; bus64.FlushE = 0;

    #12;
    check_e("reset", bubble());
    check("reset.StallD", 64'(bus32.StallD), 64'd0);
    rst = 1'b0;
    tick();

    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd9);
    wb_write(5'd6, 32'h100);
    wb_write(5'd5, 32'h55);

    for (int i = 0; i < 15; i++) begin
      pc = 32'h1000 + 32'(i * 16);
      drive(vecs[i].vld, vecs[i].instr, pc);
      #1;
      check($sformatf("v%0d.StallD", i), 64'(bus32.StallD), 64'(vecs[i].exp_stall));
      tick();
      ex = vecs[i].e;
      if (ex.valid) begin ex.pc = pc; ex.pc4 = pc + 32'd4; end
      check_e($sformatf("v%0d", i), ex);
    end

    // Load-use on rs1: one stall cycle, one bubble, then the add issues.
    drive(1, I_LW_X4, 32'h2000);
    tick();
    check("lu.lwE.ResultSrcE", 64'(bus32.ResultSrcE), 64'd1);
    drive(1, I_ADD_5_4_2, 32'h2004);
    #1;
    check("lu.StallD", 64'(bus32.StallD), 64'd1);
    tick();
    check("lu.bubble.ValidE", 64'(bus32.ValidE), 64'd0);
    check("lu.bubble.RegWriteE", 64'(bus32.RegWriteE), 64'd0);
    check("lu.StallD_cleared", 64'(bus32.StallD), 64'd0);
    tick();
    ex = mk_e(1,1,0,0,0,0,3'b000, 0, 9, 0, 0, 4, 2, 5);
    ex.pc = 32'h2004; ex.pc4 = 32'h2008;
    check_e("lu.addE", ex);

    // Load-use on rs2.
    drive(1, I_LW_X4, 32'h2010);
    tick();
    drive(1, I_ADD_5_2_4, 32'h2014);
    #1;
    check("lu2.StallD", 64'(bus32.StallD), 64'd1);
    tick();
    check("lu2.bubble.ValidE", 64'(bus32.ValidE), 64'd0);
    tick();
    check("lu2.addE.ValidE", 64'(bus32.ValidE), 64'd1);

    // Flush with beq in D.
    drive(1, I_BEQ_P16, 32'h3000);
    bus32.FlushE = 1'b1;
    tick();
    bus32.FlushE = 1'b0;
    check_e("flush", bubble());

    // Flush coinciding with a load-use stall: StallD still high, E bubbles.
    drive(1, I_LW_X4, 32'h3010);
    tick();
    drive(1, I_ADD_5_4_2, 32'h3014);
    bus32.FlushE = 1'b1;
    #1;
    check("flst.StallD", 64'(bus32.StallD), 64'd1);
    tick();
    bus32.FlushE = 1'b0;
    check("flst.ValidE", 64'(bus32.ValidE), 64'd0);
    check("flst.RegWriteE", 64'(bus32.RegWriteE), 64'd0);

    // Same-cycle write and read of x6.
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'hDEAD;
`else
    exp_bypass = 32'h100;
`endif
    drive(1, I_ADD_7_6_0, 32'h4000);
    bus32.RegWriteW = 1'b1; bus32.RDW = 5'd6; bus32.ResultW = 32'hDEAD;
    tick();
    bus32.RegWriteW = 1'b0;
    check("byp.RD1_E", 64'(bus32.RD1_E), 64'(exp_bypass));
    tick();
    check("byp.later.RD1_E", 64'(bus32.RD1_E), 64'h0000DEAD);

    // Writes to x0 are dropped, including any same-cycle bypass.
    drive(1, I_ADD_7_0_0, 32'h4010);
    bus32.RegWriteW = 1'b1; bus32.RDW = 5'd0; bus32.ResultW = 32'h1234;
    tick();
    bus32.RegWriteW = 1'b0;
    check("x0.same.RD1_E", 64'(bus32.RD1_E), 64'd0);
    check("x0.same.RD2_E", 64'(bus32.RD2_E), 64'd0);
    tick();
    check("x0.later.RD1_E", 64'(bus32.RD1_E), 64'd0);

    // Reset mid-run: x5 holds 0x55, a load sits in E with a stalled consumer.
    drive(1, I_ADD_7_5_0, 32'h5000);
    tick();
    check("pre_rst.x5", 64'(bus32.RD1_E), 64'h55);
    drive(1, I_LW_X4, 32'h5004);
    tick();
    drive(1, I_ADD_5_4_2, 32'h5008);
    #1;
    check("pre_rst.StallD", 64'(bus32.StallD), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_e("rst_mid", bubble());
    check("rst_mid.StallD", 64'(bus32.StallD), 64'd0);
    #3 rst = 1'b0;
    drive(1, I_ADD_7_5_0, 32'h5010);
    tick();
    check("post_rst.x5", 64'(bus32.RD1_E), 64'd0);
    check("post_rst.ValidE", 64'(bus32.ValidE), 64'd1);

    // XLEN=64: store immediate -4 sign-extends across the full width.
    bus64.ValidD   = 1'b1;
    bus64.InstrD   = I_SW_M4;
    bus64.PCD      = 64'h8000_0000_0000_0010;
    bus64.PCPlus4D = 64'h8000_0000_0000_0014;
    tick();
    check("x64.Imm_Ext_E", bus64.Imm_Ext_E, 64'hFFFF_FFFF_FFFF_FFFC);
    check("x64.MemWriteE", 64'(bus64.MemWriteE), 64'd1);
    check("x64.ValidE", 64'(bus64.ValidE), 64'd1);
    check("x64.RegWriteE", 64'(bus64.RegWriteE), 64'd0);
    check("x64.PCE", bus64.PCE, 64'h8000_0000_0000_0010);
    check("x64.Rs2E", 64'(bus64.Rs2E), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
